// File: rtl/test_seq_pkg.sv
// Shared types and constants for the method-test sequencer.
package test_seq_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int IDX_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RECORD,
        NEXT,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/seq_timeout_counter.sv
// Saturating up-counter that flags when it has reached LIMIT-1.
module seq_timeout_counter #(
    parameter int CNT_W = 32,
    parameter int LIMIT = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic             expired,
    output logic [CNT_W-1:0] count
);

    // A zero limit behaves like a limit of one rather than wrapping.
    localparam logic [CNT_W-1:0] LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count   = count_reg;
    assign expired = (count_reg == LAST);

endmodule

// File: rtl/test_method_sequencer.sv
// Runs N req/busy/return method blocks in turn and collects a pass/fail/timeout verdict.
module test_method_sequencer
    import test_seq_pkg::*;
#(
    parameter int N_TESTS     = 4,
    parameter int START_DELAY = 100,
    parameter int TIMEOUT     = 10000,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [N_TESTS-1:0] test_req,
    input  logic [N_TESTS-1:0] test_busy,
    input  logic [N_TESTS-1:0] test_return,
    output logic               running,
    output logic               done,
    output logic               pass,
    output logic [N_TESTS-1:0] fail_mask,
    output logic [N_TESTS-1:0] timeout_mask,
    output logic [7:0]         pass_count,
    output logic [7:0]         cur_index
);

    seq_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   cur_index_reg, cur_index_next;
    logic [IDX_W-1:0]   pass_count_reg, pass_count_next;
    logic [N_TESTS-1:0] fail_mask_reg, fail_mask_next;
    logic [N_TESTS-1:0] timeout_mask_reg, timeout_mask_next;
    logic               ret_reg, ret_next;

    logic [N_TESTS-1:0] sel_mask;
    logic               sel_busy, sel_return, req_active, in_test, is_last;
    logic               dly_expired, tmo_expired;
    logic [CNT_W-1:0]   dly_count, tmo_count;
    logic               unused_counts;

    // The timeout window includes the ISSUE cycle, so the counter runs there too.
    assign in_test    = (state_reg == ISSUE) || (state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE);
    assign req_active = (state_reg == ISSUE) || (state_reg == WAIT_BUSY);
    assign is_last    = (cur_index_reg == IDX_W'(N_TESTS - 1));

    seq_timeout_counter #(.CNT_W(CNT_W), .LIMIT(START_DELAY)) u_delay_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_reg != DELAY),
        .enable  (state_reg == DELAY),
        .expired (dly_expired),
        .count   (dly_count)
    );

    seq_timeout_counter #(.CNT_W(CNT_W), .LIMIT(TIMEOUT)) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_test),
        .enable  (in_test),
        .expired (tmo_expired),
        .count   (tmo_count)
    );

    assign unused_counts = &{1'b0, dly_count, tmo_count};

    genvar gi;
    generate
        for (gi = 0; gi < N_TESTS; gi++) begin : g_sel
            assign sel_mask[gi] = (cur_index_reg == IDX_W'(gi));
            assign test_req[gi] = req_active && sel_mask[gi];
        end
    endgenerate

    assign sel_busy   = |(test_busy & sel_mask);
    assign sel_return = |(test_return & sel_mask);

    always_comb begin
        state_next        = state_reg;
        cur_index_next    = cur_index_reg;
        pass_count_next   = pass_count_reg;
        fail_mask_next    = fail_mask_reg;
        timeout_mask_next = timeout_mask_reg;
        ret_next          = ret_reg;
        case (state_reg)
            IDLE, FINISH: begin
                if (start) begin
                    cur_index_next    = '0;
                    pass_count_next   = '0;
                    fail_mask_next    = '0;
                    timeout_mask_next = '0;
                    state_next        = DELAY;
                end
            end
            DELAY: if (dly_expired) state_next = ISSUE;
            ISSUE: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (sel_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_expired) begin
                    fail_mask_next    = fail_mask_reg | sel_mask;
                    timeout_mask_next = timeout_mask_reg | sel_mask;
                    state_next        = NEXT;
                end
            end
            WAIT_DONE: begin
                // Completion is checked first so it wins a tie with the timeout.
                if (!sel_busy) begin
                    ret_next   = sel_return;
                    state_next = RECORD;
                end else if (tmo_expired) begin
                    fail_mask_next    = fail_mask_reg | sel_mask;
                    timeout_mask_next = timeout_mask_reg | sel_mask;
                    state_next        = NEXT;
                end
            end
            RECORD: begin
                if (ret_reg) pass_count_next = pass_count_reg + IDX_W'(1);
                else         fail_mask_next  = fail_mask_reg | sel_mask;
                state_next = NEXT;
            end
            NEXT: begin
                if (is_last) begin
                    state_next = FINISH;
                end else begin
                    cur_index_next = cur_index_reg + IDX_W'(1);
                    state_next     = ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            cur_index_reg    <= '0;
            pass_count_reg   <= '0;
            fail_mask_reg    <= '0;
            timeout_mask_reg <= '0;
            ret_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cur_index_reg    <= cur_index_next;
            pass_count_reg   <= pass_count_next;
            fail_mask_reg    <= fail_mask_next;
            timeout_mask_reg <= timeout_mask_next;
            ret_reg          <= ret_next;
        end
    end

    assign running      = (state_reg != IDLE) && (state_reg != FINISH);
    assign done         = (state_reg == FINISH);
    assign pass         = done && (fail_mask_reg == '0);
    assign fail_mask    = fail_mask_reg;
    assign timeout_mask = timeout_mask_reg;
    assign pass_count   = pass_count_reg;
    assign cur_index    = cur_index_reg;

endmodule
